// File: rtl/axis_switch_pkg.sv
// -----------------------------------------------------------------------------
// axis_switch_pkg
//
// Shared types and helpers for the AXI-Stream switch arbiters.
//   arb_state_t : two-state arbitration FSM encoding (IDLE, GRANT).
//   rr_next()   : round-robin winner search. Starting at ptr, walks
//                 ptr, ptr+1, ... wrapping at num (not at a power of two) and
//                 returns the first index whose request bit is set. When
//                 nothing requests, ptr is returned and the caller is expected
//                 to qualify the result with its own any-request flag.
// -----------------------------------------------------------------------------
package axis_switch_pkg;

    localparam int MAX_SLAVES = 16;
    localparam int MAX_IDX_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int unsigned rr_next(
        input int unsigned           ptr,
        input logic [MAX_SLAVES-1:0] req,
        input int unsigned           num
    );
        int unsigned win;
        int unsigned idx;
        logic        found;
        win   = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_SLAVES; k++) begin
            // ptr < num and k < num, so one subtraction is enough to wrap.
            idx = ptr + k;
            if (idx >= num) begin
                idx = idx - num;
            end
            if ((k < num) && !found && req[idx[MAX_IDX_W-1:0]]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage : axis_switch_pkg

// File: rtl/rr_priority_select.sv
// -----------------------------------------------------------------------------
// rr_priority_select
//
// Combinational round-robin priority encoder.
//   req_i     [NUM_SLAVES] : request vector (one bit per slave).
//   ptr_i     [IDX_W]      : index holding highest priority this round.
//   grant_o   [IDX_W]      : first requesting index at or after ptr_i,
//                            wrapping at NUM_SLAVES.
//   any_req_o              : at least one request bit is set; grant_o is
//                            only meaningful when this is high.
// -----------------------------------------------------------------------------
module rr_priority_select
    import axis_switch_pkg::*;
#(
    parameter  int NUM_SLAVES = 4,
    localparam int IDX_W      = $clog2(NUM_SLAVES)
) (
    input  logic [NUM_SLAVES-1:0] req_i,
    input  logic [IDX_W-1:0]      ptr_i,
    output logic [IDX_W-1:0]      grant_o,
    output logic                  any_req_o
);

    always_comb begin
        grant_o   = IDX_W'(rr_next(32'(ptr_i), MAX_SLAVES'(req_i), NUM_SLAVES));
        any_req_o = |req_i;
    end

endmodule : rr_priority_select

// File: rtl/axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter
//
// N-to-1 AXI-Stream round-robin arbiter with one full-throughput output
// register stage. A grant lasts for a whole packet (up to the accepted TLAST
// beat) when HAS_LAST=1, or for a single beat when HAS_LAST=0. Each grant
// costs one arbitration cycle in IDLE.
//
// Ports:
//   aclk, aresetn          : clock, asynchronous active-low reset.
//   s_valid/s_ready/s_last : per-slave handshake and TLAST (NUM_SLAVES bits).
//   s_data, s_dest         : packed per-slave payload, slave i at
//                            [i*W +: W].
//   m_valid/m_ready        : downstream handshake.
//   m_data/m_dest/m_last   : registered payload of the forwarded beat.
//   m_id                   : index of the slave that produced the beat.
// -----------------------------------------------------------------------------
module axis_rr_arbiter
    import axis_switch_pkg::*;
#(
    parameter  int NUM_SLAVES = 4,
    parameter  int DATA_WIDTH = 64,
    parameter  int DEST_WIDTH = 1,
    parameter  int HAS_LAST   = 1,
    localparam int IDX_W      = $clog2(NUM_SLAVES)
) (
    input  logic                             aclk,
    input  logic                             aresetn,

    input  logic [NUM_SLAVES-1:0]            s_valid,
    output logic [NUM_SLAVES-1:0]            s_ready,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_SLAVES*DEST_WIDTH-1:0] s_dest,
    input  logic [NUM_SLAVES-1:0]            s_last,

    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic [DEST_WIDTH-1:0]            m_dest,
    output logic [IDX_W-1:0]                 m_id,
    output logic                             m_last
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       sel_q,   sel_d;
    logic [IDX_W-1:0]       ptr_q,   ptr_d;

    logic                   m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0]  m_data_q,  m_data_d;
    logic [DEST_WIDTH-1:0]  m_dest_q,  m_dest_d;
    logic [IDX_W-1:0]       m_id_q,    m_id_d;
    logic                   m_last_q,  m_last_d;

    // -------------------------------------------------------------------------
    // Round-robin search over the raw requests, used only from IDLE
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] win_idx;
    logic             any_req;

    rr_priority_select #(
        .NUM_SLAVES (NUM_SLAVES)
    ) u_rr_select (
        .req_i     (s_valid),
        .ptr_i     (ptr_q),
        .grant_o   (win_idx),
        .any_req_o (any_req)
    );

    // -------------------------------------------------------------------------
    // Input demux: unpack the flat slave buses, then pick the granted slave
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] data_arr [NUM_SLAVES];
    logic [DEST_WIDTH-1:0] dest_arr [NUM_SLAVES];

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_unpack
        assign data_arr[i] = s_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign dest_arr[i] = s_dest[i*DEST_WIDTH +: DEST_WIDTH];
    end

    logic             out_free;   // output register can take a beat this cycle
    logic             accept;     // granted slave hands over a beat
    logic             grant_end;  // accepted beat closes the grant
    logic             beat_last;  // TLAST forwarded downstream
    logic [IDX_W-1:0] sel_inc;    // sel+1, wrapping at NUM_SLAVES

    always_comb begin
        out_free  = !m_valid_q || m_ready;
        accept    = (state_q == GRANT) && s_valid[sel_q] && out_free;
        beat_last = (HAS_LAST != 0) ? s_last[sel_q] : 1'b0;
        grant_end = (HAS_LAST != 0) ? s_last[sel_q] : 1'b1;
        // Explicit wrap so non-power-of-two slave counts never visit
        // indices that do not exist.
        sel_inc   = (sel_q == IDX_W'(NUM_SLAVES - 1)) ? '0 : sel_q + 1'b1;
    end

    // Only the granted slave ever sees ready, and only when the output
    // register can absorb the beat. IDLE never asserts ready.
    always_comb begin
        s_ready = '0;
        if ((state_q == GRANT) && out_free) begin
            s_ready[sel_q] = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic: arbitration FSM and output register
    // -------------------------------------------------------------------------
    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_dest_d  = m_dest_q;
        m_id_d    = m_id_q;
        m_last_d  = m_last_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    sel_d   = win_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Other requesters are ignored for the whole grant, even if
                // the granted slave pauses mid-packet.
                if (accept && grant_end) begin
                    ptr_d   = sel_inc;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A load wins over a drain, which gives a simultaneous drain+load
        // full throughput. Without a load, a handshake empties the register.
        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = data_arr[sel_q];
            m_dest_d  = dest_arr[sel_q];
            m_id_d    = sel_q;
            m_last_d  = beat_last;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // NOTE: state is updated only with non-blocking assignments under an
    // asynchronous active-low reset; the payload registers are reset too so
    // the outputs read as zero straight out of reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            ptr_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_dest_q  <= '0;
            m_id_q    <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_dest_q  <= m_dest_d;
            m_id_q    <= m_id_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_dest  = m_dest_q;
    assign m_id    = m_id_q;
    assign m_last  = m_last_q;

endmodule : axis_rr_arbiter
